// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the sensor sources, the frame arbiter and uart_tx.
//   src_valid/src_data/src_ready : per-source byte request and one-hot accept strobe
//   tx_data/tx_valid/tx_ready    : byte stream towards uart_tx
//   busy/cur_src                 : frame-in-progress flag and ID of the framed source
// master = the arbiter, slave = the surrounding environment.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [N_SRC-1:0]            src_valid;
    logic [N_SRC*DATA_WIDTH-1:0] src_data;
    logic [N_SRC-1:0]            src_ready;
    logic [DATA_WIDTH-1:0]       tx_data;
    logic                        tx_valid;
    logic                        tx_ready;
    logic                        busy;
    logic [3:0]                  cur_src;

    modport master (
        input  src_valid, src_data, tx_ready,
        output src_ready, tx_data, tx_valid, busy, cur_src
    );

    modport slave (
        output src_valid, src_data, tx_ready,
        input  src_ready, tx_data, tx_valid, busy, cur_src
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel between N_SRC sources.
// Each accepted source byte is sent as a 3-byte frame:
//   {SYNC_NIBBLE, source id}, data byte, header ^ data.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset (wins over every handshake)
//   bus : uart_tx_arbiter_if master modport (source requests, tx stream, status)
module uart_tx_arbiter #(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter logic [3:0]  SYNC_NIBBLE = 4'hA
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.master bus
);
    localparam int unsigned IdxW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {StIdle, StHdr, StData, StCsum} state_e;

    state_e                state_q;
    logic [3:0]            last_grant_q;
    logic [3:0]            cur_src_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] hdr_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_valid_q;
    logic                  busy_q;

    logic                  grant_found;
    logic [IdxW-1:0]       grant_sel;
    logic [IdxW-1:0]       cand;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [DATA_WIDTH-1:0] hdr_new;
    logic [N_SRC-1:0]      src_ready_d;
    logic                  tx_fire;

    // Search starts just after the last winner and wraps, so the first hit is
    // the round-robin winner.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            cand = IdxW'((32'(last_grant_q) + k) % N_SRC);
            if (!grant_found && bus.src_valid[cand]) begin
                grant_found = 1'b1;
                grant_sel   = cand;
            end
        end
    end

    assign grant_data = DATA_WIDTH'(bus.src_data >> (32'(grant_sel) * DATA_WIDTH));
    assign hdr_new    = DATA_WIDTH'({SYNC_NIBBLE, 4'(grant_sel)});
    assign tx_fire    = tx_valid_q & bus.tx_ready;

    // Accept strobe only while idle and out of reset; the byte moves this cycle.
    always_comb begin
        src_ready_d = '0;
        if (!rst && state_q == StIdle && grant_found) begin
            src_ready_d[grant_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 4'(N_SRC - 1);
            cur_src_q    <= '0;
            data_q       <= '0;
            hdr_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        data_q       <= grant_data;
                        cur_src_q    <= 4'(grant_sel);
                        last_grant_q <= 4'(grant_sel);
                        hdr_q        <= hdr_new;
                        tx_data_q    <= hdr_new;
                        tx_valid_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= StHdr;
                    end
                end
                StHdr: begin
                    if (tx_fire) begin
                        tx_data_q <= data_q;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (tx_fire) begin
                        tx_data_q <= hdr_q ^ data_q;
                        state_q   <= StCsum;
                    end
                end
                StCsum: begin
                    // Always pass through idle: no back-to-back frames.
                    if (tx_fire) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.src_ready = src_ready_d;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.busy      = busy_q;
    assign bus.cur_src   = cur_src_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// frames checked against a round-robin reference model.
module tb_uart_tx_arbiter;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_SRC(N), .DATA_WIDTH(8)) bus ();

    uart_tx_arbiter #(
        .N_SRC      (N),
        .DATA_WIDTH (8),
        .SYNC_NIBBLE(4'hA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks    = 0;
    int n_fail      = 0;
    int stray_ready = 0;
    int ref_last    = N - 1;

    // Reference model: round-robin winner from the previous grant.
    function automatic int model_winner(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (((req >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] hdr_of(input int s);
        return {4'hA, 4'(s)};
    endfunction

    task automatic set_src(input int i, input logic [7:0] d, input logic v);
        bus.src_data[i*8 +: 8] = d;
        bus.src_valid[i]       = v;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        bus.src_valid = '0;
        bus.tx_ready  = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        ref_last = N - 1;
    endtask

    // Waits for the next accepted tx byte; returns at the negedge before its transfer.
    task automatic get_byte(input int ready_pct, output logic [7:0] b, output bit ok,
                            inout int cycles);
        ok = 1'b0;
        b  = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            cycles++;
            if (bus.src_ready !== '0) stray_ready++;
            bus.tx_ready = ($urandom_range(99) < ready_pct);
            if (bus.tx_valid && bus.tx_ready) begin
                b  = bus.tx_data;
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Called at a negedge in idle with requests applied; ends at the idle negedge after.
    task automatic run_frame(input int ready_pct, input bit drop, output logic [N-1:0] rdy,
                             output logic [3:0] src, output logic [7:0] b0,
                             output logic [7:0] b1, output logic [7:0] b2, output bit ok,
                             output int cycles);
        bit o0, o1, o2;
        cycles = 0;
        #1;
        rdy = bus.src_ready;
        @(posedge clk);
        #1;
        if (drop) bus.src_valid = bus.src_valid & ~rdy;
        get_byte(ready_pct, b0, o0, cycles);
        src = bus.cur_src;
        get_byte(ready_pct, b1, o1, cycles);
        get_byte(ready_pct, b2, o2, cycles);
        @(negedge clk);
        ok = o0 & o1 & o2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.src_data  = '1;
        bus.src_valid = '1;
        bus.tx_ready  = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.src_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_src_ready: got %b, expected 0", bus.src_ready);
        end
        n_checks++;
        if ({bus.tx_valid, bus.busy, bus.cur_src, bus.tx_data} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: tx_valid=%b busy=%b cur_src=%0d tx_data=%h, expected all 0",
                     bus.tx_valid, bus.busy, bus.cur_src, bus.tx_data);
        end
        bus.src_valid = '0;
        rst = 1'b0;
        ref_last = N - 1;
        @(negedge clk);
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: tx_valid=%b busy=%b, expected 0 0", bus.tx_valid, bus.busy);
        end
    endtask

    task automatic test_single;
        logic [N-1:0] rdy; logic [3:0] src; logic [7:0] b0, b1, b2; bit ok; int cyc;
        do_reset();
        stray_ready = 0;
        set_src(2, 8'h5C, 1'b1);
        run_frame(100, 1'b1, rdy, src, b0, b1, b2, ok, cyc);
        n_checks++;
        if (rdy !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: src_ready=%b, expected 0100", rdy);
        end
        n_checks++;
        if (!ok || {b0, b1, b2} !== 24'hA2_5C_FE || src !== 4'd2) begin
            n_fail++;
            $display("FAIL single_frame: got %h %h %h src=%0d ok=%0b, expected a2 5c fe src=2",
                     b0, b1, b2, src, ok);
        end
        n_checks++;
        if (cyc !== 3 || stray_ready !== 0) begin
            n_fail++;
            $display("FAIL single_timing: %0d cycles, %0d stray src_ready, expected 3 and 0",
                     cyc, stray_ready);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: busy=%b tx_valid=%b, expected 0 0", bus.busy, bus.tx_valid);
        end
        ref_last = 2;
    endtask

    task automatic test_all_request;
        logic [N-1:0] rdy; logic [3:0] src; logic [7:0] b0, b1, b2; bit ok; int cyc;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] exp_oh;
        logic [7:0] d;
        do_reset();
        stray_ready = 0;
        for (int i = 0; i < N; i++) set_src(i, 8'h10 + 8'(i), 1'b1);
        for (int f = 0; f < 5; f++) begin
            exp_oh = '0;
            exp_oh[order[f]] = 1'b1;
            d = 8'h10 + 8'(order[f]);
            n_checks++;
            if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL all_idle_gap frame %0d: busy=%b tx_valid=%b, expected 0 0",
                         f, bus.busy, bus.tx_valid);
            end
            run_frame(100, 1'b0, rdy, src, b0, b1, b2, ok, cyc);
            n_checks++;
            if (!ok || rdy !== exp_oh || {b0, b1, b2} !== {hdr_of(order[f]), d, hdr_of(order[f]) ^ d}) begin
                n_fail++;
                $display("FAIL all_frame %0d: rdy=%b bytes=%h %h %h ok=%0b, expected rdy=%b bytes=%h %h %h",
                         f, rdy, b0, b1, b2, ok, exp_oh, hdr_of(order[f]), d, hdr_of(order[f]) ^ d);
            end
        end
        n_checks++;
        if (stray_ready !== 0) begin
            n_fail++;
            $display("FAIL all_ready_once: %0d stray src_ready cycles, expected 0", stray_ready);
        end
        bus.src_valid = '0;
        ref_last = 0;
    endtask

    task automatic test_backpressure;
        int bad = 0;
        do_reset();
        set_src(1, 8'h3C, 1'b1);
        #1;
        n_checks++;
        if (bus.src_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_grant: src_ready=%b, expected 0010", bus.src_ready);
        end
        @(posedge clk);
        #1;
        bus.src_valid = '0;
        @(negedge clk);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h3C || bus.busy !== 1'b1) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_stall: %0d unstable cycles, expected 0 (tx_data=%h)", bad, bus.tx_data);
        end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h9D) begin
            n_fail++;
            $display("FAIL bp_csum: tx_valid=%b tx_data=%h, expected 1 9d", bus.tx_valid, bus.tx_data);
        end
        @(negedge clk);
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: tx_valid=%b busy=%b, expected 0 0", bus.tx_valid, bus.busy);
        end
        ref_last = 1;
    endtask

    task automatic test_wraparound;
        logic [N-1:0] rdy; logic [3:0] src; logic [7:0] b0, b1, b2; bit ok; int cyc;
        do_reset();
        set_src(3, 8'h77, 1'b1);
        run_frame(100, 1'b1, rdy, src, b0, b1, b2, ok, cyc);
        n_checks++;
        if (!ok || rdy !== 4'b1000 || b0 !== 8'hA3) begin
            n_fail++;
            $display("FAIL wrap_setup: rdy=%b hdr=%h, expected 1000 a3", rdy, b0);
        end
        set_src(0, 8'h01, 1'b1);
        set_src(3, 8'h33, 1'b1);
        run_frame(100, 1'b1, rdy, src, b0, b1, b2, ok, cyc);
        n_checks++;
        if (!ok || rdy !== 4'b0001 || {b0, b1, b2} !== 24'hA0_01_A1) begin
            n_fail++;
            $display("FAIL wrap_first: rdy=%b bytes=%h %h %h, expected 0001 a0 01 a1", rdy, b0, b1, b2);
        end
        run_frame(100, 1'b1, rdy, src, b0, b1, b2, ok, cyc);
        n_checks++;
        if (!ok || rdy !== 4'b1000 || {b0, b1, b2} !== 24'hA3_33_90) begin
            n_fail++;
            $display("FAIL wrap_second: rdy=%b bytes=%h %h %h, expected 1000 a3 33 90", rdy, b0, b1, b2);
        end
        ref_last = 3;
    endtask

    task automatic test_reset_mid_frame;
        logic [N-1:0] rdy; logic [3:0] src; logic [7:0] b0, b1, b2; bit ok; int cyc;
        do_reset();
        set_src(0, 8'h44, 1'b1);
        @(posedge clk);
        #1;
        bus.src_valid = '0;
        @(negedge clk);
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA0) begin
            n_fail++;
            $display("FAIL rmid_hdr: tx_valid=%b tx_data=%h, expected 1 a0", bus.tx_valid, bus.tx_data);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_abort: tx_valid=%b busy=%b, expected 0 0", bus.tx_valid, bus.busy);
        end
        // With last_grant back at 3, source 0 beats source 1.
        set_src(0, 8'h55, 1'b1);
        set_src(1, 8'h66, 1'b1);
        run_frame(100, 1'b1, rdy, src, b0, b1, b2, ok, cyc);
        n_checks++;
        if (!ok || rdy !== 4'b0001 || b0 !== 8'hA0) begin
            n_fail++;
            $display("FAIL rmid_last_grant: rdy=%b hdr=%h, expected 0001 a0", rdy, b0);
        end
        run_frame(100, 1'b1, rdy, src, b0, b1, b2, ok, cyc);
        n_checks++;
        if (!ok || {b0, b1, b2} !== 24'hA1_66_C7 || src !== 4'd1) begin
            n_fail++;
            $display("FAIL rmid_src1: bytes=%h %h %h src=%0d, expected a1 66 c7 src=1", b0, b1, b2, src);
        end
        ref_last = 1;
    endtask

    task automatic test_idle;
        logic [N-1:0] rdy; logic [3:0] src; logic [7:0] b0, b1, b2; bit ok; int cyc;
        int bad = 0;
        int w;
        logic [N-1:0] exp_oh;
        bus.src_valid = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bus.tx_ready = 1'($urandom_range(1));
            #1;
            if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.src_ready !== '0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL idle_quiet: %0d active cycles, expected 0", bad);
        end
        @(negedge clk);
        w = model_winner(ref_last, 4'b0111);
        exp_oh = '0;
        exp_oh[w] = 1'b1;
        for (int i = 0; i < 3; i++) set_src(i, 8'hC0 + 8'(i), 1'b1);
        run_frame(100, 1'b1, rdy, src, b0, b1, b2, ok, cyc);
        n_checks++;
        if (!ok || rdy !== exp_oh || b0 !== hdr_of(w)) begin
            n_fail++;
            $display("FAIL idle_last_grant: rdy=%b hdr=%h, expected %b %h", rdy, b0, exp_oh, hdr_of(w));
        end
        bus.src_valid = '0;
    endtask

    task automatic test_random;
        logic [N-1:0] rdy; logic [3:0] src; logic [7:0] b0, b1, b2; bit ok; int cyc;
        logic [N-1:0] pend;
        logic [7:0] dat [N];
        logic [N-1:0] exp_oh;
        logic [7:0] h;
        int w;
        do_reset();
        pend = '0;
        for (int f = 0; f < 60; f++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    dat[i]  = 8'($urandom);
                    set_src(i, dat[i], 1'b1);
                end
            end
            if (pend == '0) begin
                w = int'($urandom_range(N - 1));
                pend[w] = 1'b1;
                dat[w]  = 8'($urandom);
                set_src(w, dat[w], 1'b1);
            end
            w = model_winner(ref_last, pend);
            exp_oh = '0;
            exp_oh[w] = 1'b1;
            h = hdr_of(w);
            run_frame(60, 1'b1, rdy, src, b0, b1, b2, ok, cyc);
            n_checks++;
            if (!ok || rdy !== exp_oh || src !== 4'(w) || {b0, b1, b2} !== {h, dat[w], h ^ dat[w]}) begin
                n_fail++;
                $display("FAIL random_frame %0d: rdy=%b src=%0d bytes=%h %h %h ok=%0b, expected %b %0d %h %h %h",
                         f, rdy, src, b0, b1, b2, ok, exp_oh, w, h, dat[w], h ^ dat[w]);
            end
            pend[w]  = 1'b0;
            ref_last = w;
        end
        bus.src_valid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.src_valid = '0;
        bus.src_data  = '0;
        bus.tx_ready  = 1'b0;
        test_reset();
        test_single();
        test_all_request();
        test_backpressure();
        test_wraparound();
        test_reset_mid_frame();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
